fifo_rr_write_arbiter: RTL and testbench



---
 rtl/fifo_rr_write_arbiter.sv | 113 +++++++++++
 tb/tb_fifo_rr_write_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_write_arbiter.sv
// Round-robin arbiter sharing one synchronous FIFO write port among NUM_REQ
// valid/ready producers, granting bursts of up to MAX_BURST beats.
module fifo_rr_write_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REQ     = 4,
    parameter int MAX_BURST   = 4,
    parameter int THROTTLE_AF = 1,
    localparam int IDW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    input  logic                          fifo_full,
    input  logic                          fifo_almost_full,
    output logic                          grant_valid,
    output logic [IDW-1:0]                grant_id,
    output logic [7:0]                    burst_cnt
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    logic [0:0]            state;
    logic [IDW-1:0]        rr_ptr;
    logic [IDW-1:0]        winner;
    logic [IDW-1:0]        next_ptr;
    logic [IDW:0]          scan_idx;
    logic                  found;
    logic                  push_ok;
    logic                  g_valid;
    logic                  active;
    logic                  beat;
    logic                  last_beat;
    logic [DATA_WIDTH-1:0] slice [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign slice[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // almost_full optionally blocks too, covering the FIFO's flag update lag
    assign push_ok     = !fifo_full && !((THROTTLE_AF != 0) && fifo_almost_full);
    assign grant_valid = (state == S_BURST);
    assign g_valid     = req_valid[grant_id];
    assign active      = !rst && grant_valid;
    assign beat        = active && g_valid && push_ok;
    assign last_beat   = (burst_cnt == 8'(MAX_BURST - 1));
    assign next_ptr    = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    assign fifo_wr_en  = beat;
    assign fifo_data   = active ? slice[grant_id] : '0;

    always_comb begin
        req_ready = '0;
        if (active) begin
            req_ready[grant_id] = push_ok;
        end
    end

    // Rotating priority scan: first valid producer at or above rr_ptr, wrapping
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (scan_idx >= (IDW+1)'(NUM_REQ)) begin
                scan_idx = scan_idx - (IDW+1)'(NUM_REQ);
            end
            if (!found && req_valid[scan_idx[IDW-1:0]]) begin
                found  = 1'b1;
                winner = scan_idx[IDW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            grant_id  <= '0;
            burst_cnt <= '0;
            rr_ptr    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        state     <= S_BURST;
                        grant_id  <= winner;
                        burst_cnt <= '0;
                    end
                end
                S_BURST: begin
                    // Backpressure only stalls; dropping valid gives up the rest of the burst
                    if (!g_valid) begin
                        state  <= S_IDLE;
                        rr_ptr <= next_ptr;
                    end else if (beat) begin
                        burst_cnt <= burst_cnt + 8'd1;
                        if (last_beat) begin
                            state  <= S_IDLE;
                            rr_ptr <= next_ptr;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rr_write_arbiter.sv
// Directed bench for fifo_rr_write_arbiter; two instances differ only in THROTTLE_AF.
module tb_fifo_rr_write_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic         fifo_full;
    logic         fifo_almost_full;

    logic [3:0]  rdy_a, rdy_b;
    logic        we_a, we_b;
    logic [31:0] fd_a, fd_b;
    logic        gv_a, gv_b;
    logic [1:0]  gid_a, gid_b;
    logic [7:0]  bc_a, bc_b;

    int n_cmp = 0;
    int n_err = 0;

    fifo_rr_write_arbiter #(.DATA_WIDTH(32), .NUM_REQ(4), .MAX_BURST(4), .THROTTLE_AF(1)) dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(rdy_a),
        .fifo_wr_en(we_a), .fifo_data(fd_a), .fifo_full(fifo_full),
        .fifo_almost_full(fifo_almost_full), .grant_valid(gv_a), .grant_id(gid_a), .burst_cnt(bc_a)
    );

    fifo_rr_write_arbiter #(.DATA_WIDTH(32), .NUM_REQ(4), .MAX_BURST(4), .THROTTLE_AF(0)) dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(rdy_b),
        .fifo_wr_en(we_b), .fifo_data(fd_b), .fifo_full(fifo_full),
        .fifo_almost_full(fifo_almost_full), .grant_valid(gv_b), .grant_id(gid_b), .burst_cnt(bc_b)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] MULTI_DATA = {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        req_data = '0;
        fifo_full = 1'b0;
        fifo_almost_full = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        req_valid = 4'b1111;
        req_data = MULTI_DATA;
        #1;
        n_cmp++; if (gv_a !== 1'b0) begin n_err++; $display("FAIL reset grant_valid: got %0b want 0", gv_a); end
        n_cmp++; if (gid_a !== 2'd0) begin n_err++; $display("FAIL reset grant_id: got %0d want 0", gid_a); end
        n_cmp++; if (bc_a !== 8'd0) begin n_err++; $display("FAIL reset burst_cnt: got %0d want 0", bc_a); end
        n_cmp++; if (rdy_a !== 4'b0) begin n_err++; $display("FAIL reset req_ready: got %b want 0000", rdy_a); end
        n_cmp++; if (we_a !== 1'b0) begin n_err++; $display("FAIL reset fifo_wr_en: got %0b want 0", we_a); end
        n_cmp++; if (fd_a !== 32'h0) begin n_err++; $display("FAIL reset fifo_data: got %h want 0", fd_a); end
    endtask

    task automatic test_single_stream();
        int v[10], e_gv[10], e_bc[10], e_we[10];
        logic [31:0] d[10];
        logic [31:0] e_fd;
        do_reset();
        v    = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
        d    = '{32'hA0, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA4, 32'hA5, 32'hA5, 32'hA5};
        e_gv = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 0};
        e_bc = '{0, 0, 1, 2, 3, 4, 0, 1, 2, 2};
        e_we = '{0, 1, 1, 1, 1, 0, 1, 1, 0, 0};
        for (int c = 0; c < 10; c++) begin
            rst = 1'b0;
            req_valid = (v[c] != 0) ? 4'b0001 : 4'b0000;
            req_data = '0;
            req_data[31:0] = d[c];
            #1;
            e_fd = (e_gv[c] != 0) ? d[c] : 32'h0;
            n_cmp++; if (gv_a !== (e_gv[c] != 0)) begin n_err++; $display("FAIL stream gv c%0d: got %0b want %0d", c, gv_a, e_gv[c]); end
            n_cmp++; if (gid_a !== 2'd0) begin n_err++; $display("FAIL stream gid c%0d: got %0d want 0", c, gid_a); end
            n_cmp++; if (bc_a !== 8'(e_bc[c])) begin n_err++; $display("FAIL stream bc c%0d: got %0d want %0d", c, bc_a, e_bc[c]); end
            n_cmp++; if (we_a !== (e_we[c] != 0)) begin n_err++; $display("FAIL stream we c%0d: got %0b want %0d", c, we_a, e_we[c]); end
            n_cmp++; if (fd_a !== e_fd) begin n_err++; $display("FAIL stream data c%0d: got %h want %h", c, fd_a, e_fd); end
            n_cmp++; if (rdy_a !== ((e_gv[c] != 0) ? 4'b0001 : 4'b0000)) begin n_err++; $display("FAIL stream ready c%0d: got %b", c, rdy_a); end
            tick();
        end
    endtask

    task automatic test_round_robin();
        int p, gi;
        logic        e_gv;
        logic [7:0]  e_bc;
        logic [31:0] e_fd;
        logic [3:0]  e_rdy;
        do_reset();
        for (int c = 0; c < 23; c++) begin
            rst = 1'b0;
            req_valid = 4'b1111;
            req_data = MULTI_DATA;
            #1;
            p  = c % 5;
            gi = (c / 5) % 4;
            e_gv  = (p != 0);
            e_bc  = (p != 0) ? 8'(p - 1) : ((c == 0) ? 8'd0 : 8'd4);
            e_fd  = e_gv ? 32'hD0D0_0000 + 32'(gi) * 32'h0101_0001 : 32'h0;
            e_rdy = e_gv ? 4'(1 << gi) : 4'b0000;
            n_cmp++; if (gv_a !== e_gv) begin n_err++; $display("FAIL rr gv c%0d: got %0b want %0b", c, gv_a, e_gv); end
            if (e_gv) begin
                n_cmp++; if (gid_a !== 2'(gi)) begin n_err++; $display("FAIL rr gid c%0d: got %0d want %0d", c, gid_a, gi); end
            end
            n_cmp++; if (bc_a !== e_bc) begin n_err++; $display("FAIL rr bc c%0d: got %0d want %0d", c, bc_a, e_bc); end
            n_cmp++; if (we_a !== e_gv) begin n_err++; $display("FAIL rr we c%0d: got %0b want %0b", c, we_a, e_gv); end
            n_cmp++; if (fd_a !== e_fd) begin n_err++; $display("FAIL rr data c%0d: got %h want %h", c, fd_a, e_fd); end
            n_cmp++; if (rdy_a !== e_rdy) begin n_err++; $display("FAIL rr ready c%0d: got %b want %b", c, rdy_a, e_rdy); end
            tick();
        end
    endtask

    // use_af=0 stalls with fifo_full (both instances stall); use_af=1 with almost_full
    task automatic test_stall(input bit use_af);
        int v[10], stall[10], e_gv[10], e_bc[10], e_we[10];
        int b_gv[6], b_bc[6], b_we[6];
        logic [31:0] d[10];
        logic [31:0] e_fd;
        logic [3:0]  e_rdy;
        int pushes;
        do_reset();
        pushes = 0;
        v     = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
        stall = '{0, 0, 1, 1, 1, 0, 0, 0, 0, 0};
        d     = '{32'hB0, 32'hB0, 32'hB1, 32'hB1, 32'hB1, 32'hB1, 32'hB2, 32'hB3, 32'hB3, 32'hB3};
        e_gv  = '{0, 1, 1, 1, 1, 1, 1, 1, 0, 0};
        e_bc  = '{0, 0, 1, 1, 1, 1, 2, 3, 4, 4};
        e_we  = '{0, 1, 0, 0, 0, 1, 1, 1, 0, 0};
        b_gv  = '{0, 1, 1, 1, 1, 0};
        b_bc  = '{0, 0, 1, 2, 3, 4};
        b_we  = '{0, 1, 1, 1, 1, 0};
        for (int c = 0; c < 10; c++) begin
            rst = 1'b0;
            req_valid = (v[c] != 0) ? 4'b0100 : 4'b0000;
            req_data = '0;
            req_data[95:64] = d[c];
            fifo_full = !use_af && (stall[c] != 0);
            fifo_almost_full = use_af && (stall[c] != 0);
            #1;
            e_fd  = (e_gv[c] != 0) ? d[c] : 32'h0;
            e_rdy = ((e_gv[c] != 0) && (stall[c] == 0)) ? 4'b0100 : 4'b0000;
            if (we_a) pushes++;
            n_cmp++; if (gv_a !== (e_gv[c] != 0)) begin n_err++; $display("FAIL stall%0d gv c%0d: got %0b want %0d", use_af, c, gv_a, e_gv[c]); end
            if (e_gv[c] != 0) begin
                n_cmp++; if (gid_a !== 2'd2) begin n_err++; $display("FAIL stall%0d gid c%0d: got %0d want 2", use_af, c, gid_a); end
            end
            n_cmp++; if (bc_a !== 8'(e_bc[c])) begin n_err++; $display("FAIL stall%0d bc c%0d: got %0d want %0d", use_af, c, bc_a, e_bc[c]); end
            n_cmp++; if (we_a !== (e_we[c] != 0)) begin n_err++; $display("FAIL stall%0d we c%0d: got %0b want %0d", use_af, c, we_a, e_we[c]); end
            n_cmp++; if (rdy_a !== e_rdy) begin n_err++; $display("FAIL stall%0d ready c%0d: got %b want %b", use_af, c, rdy_a, e_rdy); end
            n_cmp++; if (fd_a !== e_fd) begin n_err++; $display("FAIL stall%0d data c%0d: got %h want %h", use_af, c, fd_a, e_fd); end
            if (!use_af) begin
                n_cmp++; if (we_b !== (e_we[c] != 0)) begin n_err++; $display("FAIL full_noaf we c%0d: got %0b want %0d", c, we_b, e_we[c]); end
            end else if (c <= 5) begin
                n_cmp++; if (gv_b !== (b_gv[c] != 0)) begin n_err++; $display("FAIL af_ignored gv c%0d: got %0b want %0d", c, gv_b, b_gv[c]); end
                n_cmp++; if (bc_b !== 8'(b_bc[c])) begin n_err++; $display("FAIL af_ignored bc c%0d: got %0d want %0d", c, bc_b, b_bc[c]); end
                n_cmp++; if (we_b !== (b_we[c] != 0)) begin n_err++; $display("FAIL af_ignored we c%0d: got %0b want %0d", c, we_b, b_we[c]); end
            end
            tick();
        end
        n_cmp++; if (pushes != 4) begin n_err++; $display("FAIL stall%0d push count: got %0d want 4", use_af, pushes); end
        fifo_full = 1'b0;
        fifo_almost_full = 1'b0;
    endtask

    task automatic test_voluntary_release();
        logic [3:0] v[8];
        int e_gv[8], e_gid[8], e_bc[8], e_we[8];
        logic [31:0] e_fd;
        logic [3:0]  e_rdy;
        do_reset();
        v     = '{4'b1010, 4'b1010, 4'b1010, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000};
        e_gv  = '{0, 1, 1, 1, 0, 1, 1, 0};
        e_gid = '{0, 1, 1, 1, 1, 3, 3, 3};
        e_bc  = '{0, 0, 1, 2, 2, 0, 1, 1};
        e_we  = '{0, 1, 1, 0, 0, 1, 0, 0};
        for (int c = 0; c < 8; c++) begin
            rst = 1'b0;
            req_valid = v[c];
            req_data = MULTI_DATA;
            #1;
            e_fd  = (e_gv[c] != 0) ? 32'hD0D0_0000 + 32'(e_gid[c]) * 32'h0101_0001 : 32'h0;
            e_rdy = (e_gv[c] != 0) ? 4'(1 << e_gid[c]) : 4'b0000;
            n_cmp++; if (gv_a !== (e_gv[c] != 0)) begin n_err++; $display("FAIL drop gv c%0d: got %0b want %0d", c, gv_a, e_gv[c]); end
            n_cmp++; if (gid_a !== 2'(e_gid[c])) begin n_err++; $display("FAIL drop gid c%0d: got %0d want %0d", c, gid_a, e_gid[c]); end
            n_cmp++; if (bc_a !== 8'(e_bc[c])) begin n_err++; $display("FAIL drop bc c%0d: got %0d want %0d", c, bc_a, e_bc[c]); end
            n_cmp++; if (we_a !== (e_we[c] != 0)) begin n_err++; $display("FAIL drop we c%0d: got %0b want %0d", c, we_a, e_we[c]); end
            n_cmp++; if (rdy_a !== e_rdy) begin n_err++; $display("FAIL drop ready c%0d: got %b want %b", c, rdy_a, e_rdy); end
            n_cmp++; if (fd_a !== e_fd) begin n_err++; $display("FAIL drop data c%0d: got %h want %h", c, fd_a, e_fd); end
            tick();
        end
    endtask

    task automatic test_reset_mid_burst();
        int r[11], e_gv[11], e_gid[11], e_bc[11], e_we[11];
        logic        live;
        logic [31:0] e_fd;
        logic [3:0]  e_rdy;
        do_reset();
        r     = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        e_gv  = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 0, 1};
        e_gid = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0};
        e_bc  = '{0, 0, 1, 2, 3, 4, 0, 1, 2, 0, 0};
        e_we  = '{0, 1, 1, 1, 1, 0, 1, 1, 0, 0, 1};
        for (int c = 0; c < 11; c++) begin
            rst = (r[c] != 0);
            req_valid = 4'b0011;
            req_data = MULTI_DATA;
            #1;
            live  = (e_gv[c] != 0) && (r[c] == 0);
            e_fd  = live ? 32'hD0D0_0000 + 32'(e_gid[c]) * 32'h0101_0001 : 32'h0;
            e_rdy = live ? 4'(1 << e_gid[c]) : 4'b0000;
            n_cmp++; if (gv_a !== (e_gv[c] != 0)) begin n_err++; $display("FAIL rstmid gv c%0d: got %0b want %0d", c, gv_a, e_gv[c]); end
            n_cmp++; if (gid_a !== 2'(e_gid[c])) begin n_err++; $display("FAIL rstmid gid c%0d: got %0d want %0d", c, gid_a, e_gid[c]); end
            n_cmp++; if (bc_a !== 8'(e_bc[c])) begin n_err++; $display("FAIL rstmid bc c%0d: got %0d want %0d", c, bc_a, e_bc[c]); end
            n_cmp++; if (we_a !== (e_we[c] != 0)) begin n_err++; $display("FAIL rstmid we c%0d: got %0b want %0d", c, we_a, e_we[c]); end
            n_cmp++; if (rdy_a !== e_rdy) begin n_err++; $display("FAIL rstmid ready c%0d: got %b want %b", c, rdy_a, e_rdy); end
            n_cmp++; if (fd_a !== e_fd) begin n_err++; $display("FAIL rstmid data c%0d: got %h want %h", c, fd_a, e_fd); end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit (got timeout, want finish)");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_stream();
        test_round_robin();
        test_stall(1'b0);
        test_stall(1'b1);
        test_voluntary_release();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
